usb_data_buffer: RTL and testbench

Byte-wide, 64-entry circular FIFO shared between the USB receive path and the AHB slave in the AHB-USB endpoint. Two producers: `usb_rx` stores decoded packet bytes; the AHB slave stores host-written TX bytes. Two consumers: the AHB slave pops RX bytes; `usb_tx` pops TX packet bytes. The block reports occupancy back to `usb_rx` and the AHB slave, and honours the flush pulse `usb_rx` issues at packet start.

---
 rtl/usb_data_buffer_if.sv | 34 +++
 rtl/usb_data_buffer.sv | 107 ++++++++++
 tb/tb_usb_data_buffer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_data_buffer_if.sv
// Byte-stream handshake bundle between the USB endpoint agents and the shared
// 64-entry data buffer: store/get strobes, data bytes, occupancy and error.
interface usb_data_buffer_if #(
    parameter int OCC_W = 7
) ();
    logic             flush;
    logic             clear;
    logic             store_rx_packet_data;
    logic [7:0]       rx_packet_data;
    logic             store_tx_data;
    logic [7:0]       tx_data;
    logic             get_rx_data;
    logic [7:0]       rx_data;
    logic             get_tx_packet_data;
    logic [7:0]       tx_packet_data;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             buffer_error;

    modport master (
        output flush, clear,
        output store_rx_packet_data, rx_packet_data,
        output store_tx_data, tx_data,
        output get_rx_data, get_tx_packet_data,
        input  rx_data, tx_packet_data, buffer_occupancy, buffer_error
    );

    modport slave (
        input  flush, clear,
        input  store_rx_packet_data, rx_packet_data,
        input  store_tx_data, tx_data,
        input  get_rx_data, get_tx_packet_data,
        output rx_data, tx_packet_data, buffer_occupancy, buffer_error
    );
endinterface

// File: rtl/usb_data_buffer.sv
// Shared byte FIFO for the AHB-USB endpoint: two producers, two consumers,
// show-ahead head byte, occupancy report and sticky misuse flag.
module usb_data_buffer #(
    parameter int DEPTH = 64,
    parameter int OCC_W = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    usb_data_buffer_if.slave bus
);
    localparam int               IDX_W     = OCC_W - 1;
    localparam logic [OCC_W-1:0] PTR_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [OCC_W-1:0] wptr_q, wptr_d;
    logic [OCC_W-1:0] rptr_q, rptr_d;
    logic             err_q, err_d;

    logic [OCC_W-1:0] occ_s;
    logic             empty_s, full_s;
    logic             push_req_s, pop_req_s;
    logic             push_ok_s, pop_ok_s;
    logic             err_event_s;
    logic             mem_we_s;
    logic             flush_s;
    logic [7:0]       push_data_s;
    logic [7:0]       head_s;

    // Request decode, acceptance and next-state pointer/error computation
    always_comb begin
        occ_s       = wptr_q - rptr_q;
        empty_s     = (occ_s == {OCC_W{1'b0}});
        full_s      = (occ_s == DEPTH_OCC);
        flush_s     = bus.flush | bus.clear;
        push_req_s  = bus.store_rx_packet_data | bus.store_tx_data;
        pop_req_s   = bus.get_rx_data | bus.get_tx_packet_data;
        pop_ok_s    = pop_req_s & ~empty_s;
        // A full buffer still takes a push when a pop frees a slot this cycle
        push_ok_s   = push_req_s & (~full_s | pop_ok_s);
        err_event_s = (bus.store_rx_packet_data & bus.store_tx_data)
                    | (push_req_s & ~push_ok_s)
                    | (pop_req_s & empty_s);
        if (bus.store_rx_packet_data) begin
            push_data_s = bus.rx_packet_data;
        end else begin
            push_data_s = bus.tx_data;
        end

        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        err_d    = err_q;
        mem_we_s = 1'b0;
        if (flush_s) begin
            wptr_d = {OCC_W{1'b0}};
            rptr_d = {OCC_W{1'b0}};
            err_d  = 1'b0;
        end else begin
            if (push_ok_s) begin
                wptr_d   = wptr_q + PTR_ONE;
                mem_we_s = 1'b1;
            end else begin
                wptr_d   = wptr_q;
                mem_we_s = 1'b0;
            end
            if (pop_ok_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
            err_d = err_q | err_event_s;
        end
    end

    // Pointer and sticky error registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q <= {OCC_W{1'b0}};
            rptr_q <= {OCC_W{1'b0}};
            err_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            err_q  <= err_d;
        end
    end

    // Byte storage; contents survive reset and flush on purpose
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wptr_q[IDX_W-1:0]] <= push_data_s;
        end
    end

    // Show-ahead head byte, forced to zero when nothing is held
    always_comb begin
        if (empty_s) begin
            head_s = 8'h00;
        end else begin
            head_s = mem_q[rptr_q[IDX_W-1:0]];
        end
        bus.rx_data          = head_s;
        bus.tx_packet_data   = head_s;
        bus.buffer_occupancy = occ_s;
        bus.buffer_error     = err_q;
    end
endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_usb_data_buffer;
    logic clk;
    logic n_rst;
    int   n_assert;
    int   n_fail;

    logic [7:0] model_q [$];
    logic       model_err;

    usb_data_buffer_if #(.OCC_W(7)) bus ();

    usb_data_buffer #(.DEPTH(64), .OCC_W(7)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (model_q.size() == 0) ? 8'h00 : model_q[0];
        chk({tag, ".occ"}, 32'(bus.buffer_occupancy), 32'(model_q.size()));
        chk({tag, ".err"}, 32'(bus.buffer_error), 32'(model_err));
        chk({tag, ".rx_data"}, 32'(bus.rx_data), 32'(head));
        chk({tag, ".tx_pkt"}, 32'(bus.tx_packet_data), 32'(head));
    endtask

    task automatic idle_inputs();
        bus.flush = 1'b0; bus.clear = 1'b0;
        bus.store_rx_packet_data = 1'b0; bus.rx_packet_data = 8'h00;
        bus.store_tx_data = 1'b0; bus.tx_data = 8'h00;
        bus.get_rx_data = 1'b0; bus.get_tx_packet_data = 1'b0;
    endtask

    // Reference behaviour expressed directly on a byte queue
    task automatic model_update(input logic srx, input logic [7:0] rxd,
                                input logic stx, input logic [7:0] txd,
                                input logic grx, input logic gtx,
                                input logic fl, input logic cl);
        bit popped;
        if (fl || cl) begin
            model_q.delete();
            model_err = 1'b0;
        end else begin
            popped = 0;
            if (srx && stx) model_err = 1'b1;
            if (grx || gtx) begin
                if (model_q.size() == 0) model_err = 1'b1;
                else begin
                    void'(model_q.pop_front());
                    popped = 1;
                end
            end
            if (srx || stx) begin
                if (model_q.size() < 64) model_q.push_back(srx ? rxd : txd);
                else model_err = 1'b1;
            end
        end
    endtask

    // Drive one cycle from the negative edge, update model, check at next negedge
    task automatic step(input logic srx, input logic [7:0] rxd,
                        input logic stx, input logic [7:0] txd,
                        input logic grx, input logic gtx,
                        input logic fl, input logic cl, input string tag);
        bus.store_rx_packet_data = srx; bus.rx_packet_data = rxd;
        bus.store_tx_data = stx; bus.tx_data = txd;
        bus.get_rx_data = grx; bus.get_tx_packet_data = gtx;
        bus.flush = fl; bus.clear = cl;
        model_update(srx, rxd, stx, txd, grx, gtx, fl, cl);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        check_state(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        model_err = 1'b0;
        idle_inputs();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check_state("reset");
        chk("reset.rx_zero", 32'(bus.rx_data), 32'h0);
        n_rst = 1'b1;
        @(negedge clk);

        // RX pushes then AHB pops in order
        step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rx_push0");
        step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rx_push1");
        step(1'b1, 8'h61, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rx_push2");
        chk("rx3.occ", 32'(bus.buffer_occupancy), 32'd3);
        chk("rx3.head", 32'(bus.rx_data), 32'h00);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "rx_pop0");
        chk("rx_pop0.head", 32'(bus.rx_data), 32'h40);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "rx_pop1");
        chk("rx_pop1.head", 32'(bus.rx_data), 32'h61);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "rx_pop2");
        chk("rx_pop2.occ", 32'(bus.buffer_occupancy), 32'd0);
        chk("rx_pop2.err", 32'(bus.buffer_error), 32'd0);

        // Fill with TX bytes, overflow, drain
        for (int i = 0; i < 64; i++)
            step(1'b0, 8'h00, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, "tx_fill");
        step(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, "tx_over");
        chk("tx_over.occ", 32'(bus.buffer_occupancy), 32'd64);
        chk("tx_over.err", 32'(bus.buffer_error), 32'd1);
        for (int i = 0; i < 64; i++) begin
            chk("tx_drain.head", 32'(bus.tx_packet_data), 32'(i));
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "tx_drain");
        end
        chk("tx_drain.empty_head", 32'(bus.tx_packet_data), 32'h0);

        // Wrap-around
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "clear0");
        for (int i = 0; i < 64; i++)
            step(1'b1, 8'(i + 8'h80), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "wrap_fill");
        for (int i = 0; i < 10; i++)
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "wrap_pop");
        for (int i = 0; i < 10; i++)
            step(1'b0, 8'h00, 1'b1, 8'(8'hF0 + i), 1'b0, 1'b0, 1'b0, 1'b0, "wrap_push");
        chk("wrap.occ", 32'(bus.buffer_occupancy), 32'd64);
        for (int i = 0; i < 54; i++)
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "wrap_drain");
        chk("wrap.head_f0", 32'(bus.rx_data), 32'hF0);
        for (int i = 0; i < 10; i++) begin
            chk("wrap.tail", 32'(bus.rx_data), 32'(8'hF0 + i));
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "wrap_tail");
        end

        // Push and pop together while full
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "clear1");
        for (int i = 0; i < 64; i++)
            step(1'b1, 8'(i + 8'h10), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "full_fill");
        step(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "full_pp");
        chk("full_pp.occ", 32'(bus.buffer_occupancy), 32'd64);
        chk("full_pp.err", 32'(bus.buffer_error), 32'd0);
        chk("full_pp.head", 32'(bus.rx_data), 32'h11);
        for (int i = 0; i < 63; i++)
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "full_drain");
        chk("full_pp.tail", 32'(bus.rx_data), 32'h77);

        // Empty-pop error, then flush beating a same-cycle store
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "flush0");
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "empty_pop");
        chk("empty_pop.err", 32'(bus.buffer_error), 32'd1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'(8'h20 + i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "pre_flush");
        step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "flush_store");
        chk("flush_store.occ", 32'(bus.buffer_occupancy), 32'd0);
        chk("flush_store.err", 32'(bus.buffer_error), 32'd0);
        step(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "post_flush");
        chk("post_flush.occ", 32'(bus.buffer_occupancy), 32'd1);
        chk("post_flush.head", 32'(bus.rx_data), 32'h3C);

        // Dual-store conflict keeps the RX byte
        step(1'b1, 8'hC3, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, "dual_store");
        chk("dual_store.err", 32'(bus.buffer_error), 32'd1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "dual_pop");
        chk("dual_store.kept", 32'(bus.rx_data), 32'hC3);
        // Empty pop with accepted push: push proceeds, error set
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "clear2");
        step(1'b0, 8'h00, 1'b1, 8'h4D, 1'b0, 1'b1, 1'b0, 1'b0, "empty_pp");
        chk("empty_pp.occ", 32'(bus.buffer_occupancy), 32'd1);
        chk("empty_pp.err", 32'(bus.buffer_error), 32'd1);

        // Randomized traffic: push-heavy then pop-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            int p_push;
            int p_pop;
            p_push = (ph % 2 == 0) ? 70 : 25;
            p_pop  = (ph % 2 == 0) ? 25 : 70;
            for (int c = 0; c < 300; c++) begin
                logic srx, stx, grx, gtx, fl, cl;
                srx = ($urandom_range(0, 99) < p_push);
                stx = ($urandom_range(0, 99) < p_push / 3);
                grx = ($urandom_range(0, 99) < p_pop);
                gtx = ($urandom_range(0, 99) < p_pop / 3);
                fl  = ($urandom_range(0, 999) < 5);
                cl  = ($urandom_range(0, 999) < 5);
                step(srx, 8'($urandom), stx, 8'($urandom), grx, gtx, fl, cl, "rand");
            end
            if (ph == 2) begin
                n_rst = 1'b0;
                #1;
                model_q.delete();
                model_err = 1'b0;
                check_state("async_reset");
                @(negedge clk);
                n_rst = 1'b1;
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
